// File: rtl/td4_pkg.sv
// Shared TD4 definitions: widths, opcodes, adder source selects and sequencer states.
package td4_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned SEL_W  = 2;

  localparam logic [OP_W-1:0] OP_ADD_A  = 4'h0;
  localparam logic [OP_W-1:0] OP_MOV_AB = 4'h1;
  localparam logic [OP_W-1:0] OP_IN_A   = 4'h2;
  localparam logic [OP_W-1:0] OP_MOV_AI = 4'h3;
  localparam logic [OP_W-1:0] OP_MOV_BA = 4'h4;
  localparam logic [OP_W-1:0] OP_ADD_B  = 4'h5;
  localparam logic [OP_W-1:0] OP_IN_B   = 4'h6;
  localparam logic [OP_W-1:0] OP_MOV_BI = 4'h7;
  localparam logic [OP_W-1:0] OP_OUT_B  = 4'h9;
  localparam logic [OP_W-1:0] OP_OUT_I  = 4'hB;
  localparam logic [OP_W-1:0] OP_JNC    = 4'hE;
  localparam logic [OP_W-1:0] OP_JMP    = 4'hF;

  localparam logic [SEL_W-1:0] SEL_A    = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B    = 2'b01;
  localparam logic [SEL_W-1:0] SEL_IN   = 2'b10;
  localparam logic [SEL_W-1:0] SEL_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/td4_decoder.sv
// Combinational TD4 instruction decoder: opcode and carry flag to strobes, source select and jump control.
module td4_decoder
  import td4_pkg::*;
(
  input  logic [DATA_W-1:0] instr,
  input  logic              carry,
  output logic [SEL_W-1:0]  sel,
  output logic [ADDR_W-1:0] imm,
  output logic              ld_n,
  output logic              load_a_n,
  output logic              load_b_n,
  output logic              load_out_n
);

  assign imm = instr[ADDR_W-1:0];

  // Unlisted opcodes fall through as NOP with the zero source selected.
  always_comb begin
    sel        = SEL_ZERO;
    ld_n       = 1'b1;
    load_a_n   = 1'b1;
    load_b_n   = 1'b1;
    load_out_n = 1'b1;
    case (instr[DATA_W-1:ADDR_W])
      OP_ADD_A:  begin sel = SEL_A;    load_a_n   = 1'b0; end
      OP_MOV_AB: begin sel = SEL_B;    load_a_n   = 1'b0; end
      OP_IN_A:   begin sel = SEL_IN;   load_a_n   = 1'b0; end
      OP_MOV_AI: begin sel = SEL_ZERO; load_a_n   = 1'b0; end
      OP_MOV_BA: begin sel = SEL_A;    load_b_n   = 1'b0; end
      OP_ADD_B:  begin sel = SEL_B;    load_b_n   = 1'b0; end
      OP_IN_B:   begin sel = SEL_IN;   load_b_n   = 1'b0; end
      OP_MOV_BI: begin sel = SEL_ZERO; load_b_n   = 1'b0; end
      OP_OUT_B:  begin sel = SEL_B;    load_out_n = 1'b0; end
      OP_OUT_I:  begin sel = SEL_ZERO; load_out_n = 1'b0; end
      OP_JNC:    ld_n = carry;
      OP_JMP:    ld_n = 1'b0;
      default:   ;
    endcase
  end

endmodule

// File: rtl/td4_fetch_decode.sv
// TD4 instruction side: program memory, load/run/halt sequencing, carry flag and decode to the datapath.
module td4_fetch_decode
  import td4_pkg::*;
#(
  parameter int unsigned MEM_DEPTH      = 16,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              alu_carry,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_start,
  input  logic              prog_mode,
  output logic              cpu_rst_n,
  output logic              ld_n,
  output logic [ADDR_W-1:0] imm,
  output logic [SEL_W-1:0]  sel,
  output logic              load_a_n,
  output logic              load_b_n,
  output logic              load_out_n,
  output logic              carry_q,
  output logic              halted
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] instr;
  logic              mem_we;

  logic [SEL_W-1:0]  dec_sel;
  logic [ADDR_W-1:0] dec_imm;
  logic              dec_ld_n;
  logic              dec_load_a_n;
  logic              dec_load_b_n;
  logic              dec_load_out_n;

  assign mem_we = (state == ST_LOAD) && prog_we && (32'(prog_addr) < MEM_DEPTH);
  assign instr  = (32'(pc) < MEM_DEPTH) ? mem[pc] : '0;

  // Program memory; reset clearing is optional so a plain RAM macro can be used.
  if (CLEAR_ON_RESET) begin : g_mem_clr
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= '0;
      end else if (mem_we) begin
        mem[prog_addr] <= prog_data;
      end
    end
  end else begin : g_mem_plain
    always_ff @(posedge clk) begin
      if (mem_we) mem[prog_addr] <= prog_data;
    end
  end

  td4_decoder u_decoder (
    .instr      (instr),
    .carry      (carry_q),
    .sel        (dec_sel),
    .imm        (dec_imm),
    .ld_n       (dec_ld_n),
    .load_a_n   (dec_load_a_n),
    .load_b_n   (dec_load_b_n),
    .load_out_n (dec_load_out_n)
  );

  // Carry tracks the adder only while instructions execute; HALT and LOAD hold it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) carry_q <= 1'b0;
    else if (state == ST_RUN) carry_q <= alu_carry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_LOAD;
    else state <= state_nxt;
  end

  // prog_mode wins over the self-jump halt detection.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (prog_start) state_nxt = ST_RUN;
      ST_RUN: begin
        if (prog_mode) state_nxt = ST_LOAD;
        else if ((instr[DATA_W-1:ADDR_W] == OP_JMP) && (instr[ADDR_W-1:0] == pc))
          state_nxt = ST_HALT;
      end
      ST_HALT: if (prog_mode) state_nxt = ST_LOAD;
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Decode reaches the datapath only while the CPU is out of reset.
  always_comb begin
    cpu_rst_n  = 1'b0;
    halted     = 1'b0;
    ld_n       = 1'b1;
    imm        = '0;
    sel        = SEL_ZERO;
    load_a_n   = 1'b1;
    load_b_n   = 1'b1;
    load_out_n = 1'b1;
    if ((state == ST_RUN) || (state == ST_HALT)) begin
      cpu_rst_n  = 1'b1;
      halted     = (state == ST_HALT);
      ld_n       = dec_ld_n;
      imm        = dec_imm;
      sel        = dec_sel;
      load_a_n   = dec_load_a_n;
      load_b_n   = dec_load_b_n;
      load_out_n = dec_load_out_n;
    end
  end

endmodule

// File: tb/tb_td4_fetch_decode.sv
// Self-checking bench for td4_fetch_decode: directed test-plan cases, then randomized traffic against a reference model.
module tb_td4_fetch_decode;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] pc = 4'h0;
  logic       alu_carry = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = 4'h0;
  logic [7:0] prog_data = 8'h00;
  logic       prog_start = 1'b0;
  logic       prog_mode = 1'b0;

  logic       cpu_rst_n, ld_n, load_a_n, load_b_n, load_out_n, carry_q, halted;
  logic [3:0] imm;
  logic [1:0] sel;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  td4_fetch_decode dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .alu_carry  (alu_carry),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_start (prog_start),
    .prog_mode  (prog_mode),
    .cpu_rst_n  (cpu_rst_n),
    .ld_n       (ld_n),
    .imm        (imm),
    .sel        (sel),
    .load_a_n   (load_a_n),
    .load_b_n   (load_b_n),
    .load_out_n (load_out_n),
    .carry_q    (carry_q),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = loading, 1 = running, 2 = halted.
  logic [7:0] m [16];
  int         mode;
  logic       c;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode <= 0;
      c    <= 1'b0;
      for (int i = 0; i < 16; i++) m[i] <= 8'h00;
    end else begin
      case (mode)
        0: begin
          if (prog_we) m[prog_addr] <= prog_data;
          if (prog_start) mode <= 1;
        end
        1: begin
          c <= alu_carry;
          if (prog_mode) mode <= 0;
          else if (m[pc] == {4'hF, pc}) mode <= 2;
        end
        default: if (prog_mode) mode <= 0;
      endcase
    end
  end

  // Expected outputs from the opcode table: 0-7 load A (op<4) or B with source op[1:0];
  // 9 and 11 load OUT with source op[1:0]; 14 jumps on clear carry; 15 always jumps.
  task automatic model_outs(input int md, input logic [7:0] w, input logic cy,
                            output logic e_rst, output logic e_halt, output logic e_ld,
                            output logic [3:0] e_imm, output logic [1:0] e_sel,
                            output logic e_a, output logic e_b, output logic e_o);
    int op;
    op = int'(w[7:4]);
    e_rst = 1'b0; e_halt = 1'b0; e_ld = 1'b1; e_imm = 4'h0; e_sel = 2'd3;
    e_a = 1'b1; e_b = 1'b1; e_o = 1'b1;
    if (md != 0) begin
      e_rst  = 1'b1;
      e_halt = (md == 2);
      e_imm  = w[3:0];
      if (op < 8) begin
        e_sel = w[5:4];
        if (op >= 4) e_b = 1'b0;
        else e_a = 1'b0;
      end else if (op == 9 || op == 11) begin
        e_sel = w[5:4];
        e_o   = 1'b0;
      end else if (op == 14) begin
        e_ld = cy;
      end else if (op == 15) begin
        e_ld = 1'b0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    logic e_rst, e_halt, e_ld, e_a, e_b, e_o;
    logic [3:0] e_imm;
    logic [1:0] e_sel;
    if (cmp_en) begin
      model_outs(mode, m[pc], c, e_rst, e_halt, e_ld, e_imm, e_sel, e_a, e_b, e_o);
      chk("m_cpu_rst_n",  4'(cpu_rst_n),  4'(e_rst));
      chk("m_halted",     4'(halted),     4'(e_halt));
      chk("m_ld_n",       4'(ld_n),       4'(e_ld));
      chk("m_imm",        imm,            e_imm);
      chk("m_sel",        4'(sel),        4'(e_sel));
      chk("m_load_a_n",   4'(load_a_n),   4'(e_a));
      chk("m_load_b_n",   4'(load_b_n),   4'(e_b));
      chk("m_load_out_n", 4'(load_out_n), 4'(e_o));
      chk("m_carry_q",    4'(carry_q),    4'(c));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_cpu_rst_n"}, 4'(cpu_rst_n), 4'd0);
    chk({tag, "_carry_q"},   4'(carry_q),   4'd0);
    chk({tag, "_halted"},    4'(halted),    4'd0);
    chk({tag, "_ld_n"},      4'(ld_n),      4'd1);
    chk({tag, "_strobes"},   {1'b0, load_a_n, load_b_n, load_out_n}, 4'h7);
    chk({tag, "_sel"},       4'(sel),       4'd3);
    chk({tag, "_imm"},       imm,           4'd0);
  endtask

  initial begin
    #1 reset = 1'b0;
    #2 check_reset_vals("rst");
    tick();
    reset = 1'b1;
    cmp_en = 1'b1;

    // Program: JMP-self halt pair, plus words for later cases.
    prog_we = 1'b1;
    prog_addr = 4'd0; prog_data = 8'h35; tick();
    prog_addr = 4'd1; prog_data = 8'hF1; tick();
    prog_addr = 4'd2; prog_data = 8'h7C; tick();
    prog_addr = 4'd3; prog_data = 8'hF3; tick();
    prog_addr = 4'd4; prog_data = 8'h0F; tick();
    prog_addr = 4'd5; prog_data = 8'hE8; tick();
    prog_addr = 4'd6; prog_data = 8'h86; tick();
    prog_we = 1'b0;
    prog_start = 1'b1; pc = 4'd0;
    #4 chk("load_cpu_rst_n", 4'(cpu_rst_n), 4'd0);
    tick();
    prog_start = 1'b0;
    #4;
    chk("run0_cpu_rst_n", 4'(cpu_rst_n), 4'd1);
    chk("run0_sel",       4'(sel),       4'd3);
    chk("run0_load_a_n",  4'(load_a_n),  4'd0);
    chk("run0_imm",       imm,           4'd5);
    tick();
    pc = 4'd1;
    #4;
    chk("jmp_ld_n",   4'(ld_n),   4'd0);
    chk("jmp_imm",    imm,        4'd1);
    chk("jmp_halted", 4'(halted), 4'd0);
    tick();
    #4;
    chk("halt_halted", 4'(halted), 4'd1);
    chk("halt_ld_n",   4'(ld_n),   4'd0);
    prog_mode = 1'b1; tick();
    prog_mode = 1'b0;
    #4 chk("halt_to_load", 4'(cpu_rst_n), 4'd0);

    // prog_mode beats the self-jump halt.
    prog_start = 1'b1; tick();
    prog_start = 1'b0; pc = 4'd3; prog_mode = 1'b1;
    #4 chk("prio_ld_n", 4'(ld_n), 4'd0);
    tick();
    prog_mode = 1'b0;
    #4;
    chk("prio_cpu_rst_n", 4'(cpu_rst_n), 4'd0);
    chk("prio_halted",    4'(halted),    4'd0);

    // JNC sees the previous instruction's carry.
    prog_start = 1'b1; tick();
    prog_start = 1'b0; pc = 4'd4; alu_carry = 1'b1;
    #4;
    chk("add_sel",  4'(sel), 4'd0);
    chk("add_imm",  imm,     4'hF);
    tick();
    pc = 4'd5; alu_carry = 1'b0;
    #4;
    chk("jnc_c1_carry", 4'(carry_q), 4'd1);
    chk("jnc_c1_ld_n",  4'(ld_n),    4'd1);
    chk("jnc_c1_imm",   imm,         4'd8);
    tick();
    pc = 4'd4; tick();
    pc = 4'd5;
    #4;
    chk("jnc_c0_ld_n", 4'(ld_n), 4'd0);
    chk("jnc_c0_imm",  imm,      4'd8);
    tick();

    // Undefined opcode is a NOP.
    pc = 4'd6;
    #4;
    chk("nop_strobes", {1'b0, load_a_n, load_b_n, load_out_n}, 4'h7);
    chk("nop_ld_n",    4'(ld_n), 4'd1);
    chk("nop_sel",     4'(sel),  4'd3);
    tick();

    // Writes outside LOAD are dropped.
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 8'hAA; tick();
    prog_we = 1'b0; prog_mode = 1'b1; tick();
    prog_mode = 1'b0; prog_start = 1'b1; tick();
    prog_start = 1'b0; pc = 4'd2;
    #4;
    chk("wprot_imm",      imm,           4'hC);
    chk("wprot_load_b_n", 4'(load_b_n),  4'd0);
    chk("wprot_sel",      4'(sel),       4'd3);
    tick();

    // Asynchronous reset mid-RUN.
    pc = 4'd4; alu_carry = 1'b1; tick();
    #1 chk("pre_rst_carry", 4'(carry_q), 4'd1);
    reset = 1'b0;
    #1 check_reset_vals("async");
    tick();
    reset = 1'b1; alu_carry = 1'b0;
    tick();

    // Randomized traffic with a bias towards self-jumps so HALT is exercised.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      prog_data  = {op, 4'($urandom_range(0, 3))};
      prog_addr  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      pc         = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      prog_we    = 1'($urandom_range(0, 1));
      alu_carry  = 1'($urandom_range(0, 1));
      prog_start = ($urandom_range(0, 5) == 0);
      prog_mode  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        tick();
        reset = 1'b1;
      end
      tick();
    end

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
